// File: rtl/fetch_stage.sv
// Instruction fetch stage and F/D pipeline latch.
// Latency: one cycle from fetch address to F/D; one instruction per cycle.
// Backpressure: stall freezes pc and F/D; redirect squashes and inserts one bubble.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   stall              decode cannot accept; hold pc and F/D latch
//   redirect_valid/pc  taken branch/jump from execute and its target
//   imem_addr          combinational next-pc word address to synchronous imem
//   q_imem             imem read data, always mem[pc] in the current cycle
//   fd_instruction/pc  F/D latch contents presented to decode
//   fd_valid           F/D latch holds a real in-path instruction
//   fetch_count        number of valid instructions loaded into F/D
module fetch_stage #(
  parameter int          IMEM_ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC        = 32'd0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                q_imem,
  output logic [31:0]                fd_instruction,
  output logic [31:0]                fd_pc,
  output logic                       fd_valid,
  output logic [31:0]                fetch_count
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] fd_instr_q;

  // The memory samples next_pc on the same edge that loads pc, so q_imem
  // always corresponds to pc during the following cycle.
  always_comb begin
    next_pc = pc + 32'd1;
    if (reset) begin
      next_pc = RESET_PC;
    end else if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (stall) begin
      next_pc = pc;
    end
  end

  assign imem_addr = next_pc[IMEM_ADDR_WIDTH-1:0];

  always_ff @(posedge clock) begin
    pc <= next_pc;
    if (reset) begin
      fd_instr_q  <= 32'd0;
      fd_pc       <= 32'd0;
      fd_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      // Squash the wrong-path word; stall is irrelevant since it is discarded.
      fd_instr_q <= 32'd0;
      fd_pc      <= 32'd0;
      fd_valid   <= 1'b0;
    end else if (!stall) begin
      fd_instr_q  <= q_imem;
      fd_pc       <= pc;
      fd_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Decode must only ever see a nop when the latch is empty.
  assign fd_instruction = fd_valid ? fd_instr_q : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table plus a redirect-then-stall
// sequence, with a synchronous instruction memory holding 32'h1000_0000 + addr.
module tb_fetch_stage;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   q_imem;
  logic [31:0]   fd_instruction;
  logic [31:0]   fd_pc;
  logic          fd_valid;
  logic [31:0]   fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.IMEM_ADDR_WIDTH(AW), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .q_imem(q_imem),
    .fd_instruction(fd_instruction), .fd_pc(fd_pc),
    .fd_valid(fd_valid), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + {20'd0, a};
  endfunction

  always @(posedge clock) q_imem <= mem_word(imem_addr);

  typedef struct {
    logic          rst;
    logic          stl;
    logic          rv;
    logic [31:0]   rpc;
    logic [AW-1:0] e_addr;   // imem_addr with inputs applied, before the edge
    logic          e_valid;  // F/D state after the edge
    logic [31:0]   e_pc;
    logic [31:0]   e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stl, input logic rv,
                     input logic [31:0] rpc, input logic [AW-1:0] ea,
                     input logic ev, input logic [31:0] ep, input logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Drive inputs at negedge, check imem_addr before the edge and F/D after it.
  task automatic step(input int idx, input vec_t v);
    logic [31:0] e_instr;
    @(negedge clock);
    reset = v.rst; stall = v.stl; redirect_valid = v.rv; redirect_pc = v.rpc;
    #1;
    chk("imem_addr", idx, {20'd0, imem_addr}, {20'd0, v.e_addr});
    @(posedge clock);
    #1;
    e_instr = v.e_valid ? mem_word(v.e_pc[AW-1:0]) : 32'd0;
    chk("fd_valid", idx, {31'd0, fd_valid}, {31'd0, v.e_valid});
    chk("fd_pc", idx, fd_pc, v.e_pc);
    chk("fd_instruction", idx, fd_instruction, e_instr);
    chk("fetch_count", idx, fetch_count, v.e_cnt);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    //   rst stl rv rpc             addr     vld pc            cnt
    add(1, 0, 0, 32'd0,          12'd0,   0, 32'd0,          32'd0);  // reset state
    add(0, 0, 0, 32'd0,          12'd1,   1, 32'd0,          32'd1);
    add(0, 0, 0, 32'd0,          12'd2,   1, 32'd1,          32'd2);
    add(0, 0, 0, 32'd0,          12'd3,   1, 32'd2,          32'd3);
    add(0, 1, 0, 32'd0,          12'd3,   1, 32'd2,          32'd3);  // stall x3
    add(0, 1, 0, 32'd0,          12'd3,   1, 32'd2,          32'd3);
    add(0, 1, 0, 32'd0,          12'd3,   1, 32'd2,          32'd3);
    add(0, 0, 0, 32'd0,          12'd4,   1, 32'd3,          32'd4);
    add(0, 0, 0, 32'd0,          12'd5,   1, 32'd4,          32'd5);  // leads fd_pc by 2 before edge
    add(0, 0, 0, 32'd0,          12'd6,   1, 32'd5,          32'd6);
    add(0, 0, 1, 32'd100,        12'd100, 0, 32'd0,          32'd6);  // redirect 100
    add(0, 0, 0, 32'd0,          12'd101, 1, 32'd100,        32'd7);
    add(0, 0, 0, 32'd0,          12'd102, 1, 32'd101,        32'd8);
    add(0, 1, 1, 32'd40,         12'd40,  0, 32'd0,          32'd8);  // redirect + stall
    add(0, 0, 0, 32'd0,          12'd41,  1, 32'd40,         32'd9);
    add(0, 0, 1, 32'hFFFF_FFFF,  12'hFFF, 0, 32'd0,          32'd9);  // wrap
    add(0, 0, 0, 32'd0,          12'h000, 1, 32'hFFFF_FFFF,  32'd10);
    add(0, 0, 0, 32'd0,          12'd1,   1, 32'd0,          32'd11);
    for (int i = 0; i < 7; i++)
      add(0, 0, 0, 32'd0, 12'(i + 2), 1, 32'(i + 1), 32'(i + 12)); // up to fd_pc 7
    add(1, 1, 1, 32'd55,         12'd0,   0, 32'd0,          32'd0);  // reset beats stall/redirect
    add(0, 0, 0, 32'd0,          12'd1,   1, 32'd0,          32'd1);
    add(0, 0, 0, 32'd0,          12'd2,   1, 32'd1,          32'd2);
    add(0, 0, 1, 32'd2,          12'd2,   0, 32'd0,          32'd2);  // redirect to own pc
    add(0, 0, 0, 32'd0,          12'd3,   1, 32'd2,          32'd3);

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Redirect followed by stall: bubble is held, target fetched once released.
    v.rst = 0; v.stl = 0; v.rv = 1; v.rpc = 32'd200;
    v.e_addr = 12'd200; v.e_valid = 0; v.e_pc = 32'd0; v.e_cnt = 32'd3;
    step(100, v);
    v.stl = 1; v.rv = 0; v.rpc = 32'd0;
    step(101, v);
    step(102, v);
    v.stl = 0; v.e_addr = 12'd201; v.e_valid = 1; v.e_pc = 32'd200; v.e_cnt = 32'd4;
    step(103, v);
    v.e_addr = 12'd202; v.e_pc = 32'd201; v.e_cnt = 32'd5;
    step(104, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
